id_imm_unit: RTL and testbench
==============================

// Module: id_imm_unit
// PURPOSE
//  Registered, parametrised immediate generator for the ID stage. Accepts a fetched instruction
//  over a valid/ready handshake, decodes its immediate (RV32/RV64 base formats, CSR zimm,
//  optional RVC subset) and presents imm/format/illegal flags to EX through a 2-entry skid buffer.
//  Sits between the IF/ID register and the ID/EX pipeline register.
// PARAMETERS
//  XLEN    32  data width; 32 or 64; immediates sign-extended to XLEN (zimm zero-extended)
//  RVC_EN  1   1: decode 16-bit compressed subset when i_instr[1:0]!=2'b11; 0: flag those illegal
// PORTS
//  i_clk      in   1     clock; one clock domain, rising edge
//  i_rst      in   1     reset, asynchronous, active-high
//  i_flush    in   1     pipeline flush (branch mispredict/trap); drops all held entries
//  i_valid    in   1     upstream instruction valid
//  o_ready    out  1     unit can accept; transfer when i_valid&&o_ready
//  i_instr    in   32    instruction word (compressed in [15:0] when [1:0]!=2'b11)
//  o_valid    out  1     decoded entry valid toward EX
//  i_ready    in   1     EX accepts; transfer when o_valid&&i_ready
//  o_imm      out  XLEN  decoded immediate
//  o_fmt      out  4     imm_fmt_e: NONE,I,S,B,U,J,Z,CI,CL,CS,CB,CJ
//  o_illegal  out  1     unknown opcode, all-zero word, or RVC with RVC_EN=0/unsupported funct
//  o_instr    out  32    instruction passthrough, aligned with o_imm
// BEHAVIOUR
//  - Reset (async): o_valid=0, o_imm=0, o_fmt=NONE, o_illegal=0, o_instr=0, skid empty, o_ready=1.
//  - Decode (32-bit): OP-IMM 0010011, LOAD 0000011, JALR 1100111 -> I; STORE 0100011 -> S;
//    BRANCH 1100011 -> B (bit0=0); LUI 0110111, AUIPC 0010111 -> U ({instr[31:12],12'b0}, sign-ext
//    from bit31 when XLEN=64); JAL 1101111 -> J; SYSTEM 1110011 with funct3[2]=1 -> Z (zext instr[19:15]);
//    OP 0110011, SYSTEM funct3[2]=0, MISC-MEM 0001111 -> NONE, imm=0, legal.
//    Any other opcode, or i_instr==0 -> NONE, imm=0, o_illegal=1.
//  - Decode (RVC, RVC_EN=1): C.ADDI/C.LI -> CI 6-bit sext; C.LUI -> CI {sext imm[17:12],12'b0};
//    C.LW -> CL, C.SW -> CS (zext offset*4); C.BEQZ/C.BNEZ -> CB 9-bit sext; C.J/C.JAL -> CJ 12-bit sext.
//    Other RVC encodings -> NONE, o_illegal=1. RVC_EN=0: any [1:0]!=2'b11 -> o_illegal=1.
//  - Latency: accepted instruction appears on o_* the next cycle (1-cycle, registered).
//  - Skid FSM, states EMPTY / ONE (output reg valid) / TWO (output + skid valid):
//    EMPTY: in -> ONE.  ONE: in&&!out -> TWO; out&&!in -> EMPTY; in&&out -> ONE (new data).
//    TWO: out -> ONE (skid moves to output reg); in impossible (o_ready=0).
//    o_ready = (state!=TWO), registered-state-derived; no combinational path i_ready->o_ready.
//  - Output regs hold stable while o_valid&&!i_ready (AXI-style stability).
//  - Order strictly preserved; no entry dropped or duplicated except on flush.
//  - i_flush: synchronous; next state EMPTY, o_valid=0; concurrent i_valid transfer discarded;
//    flush wins over simultaneous in/out. o_imm/o_fmt after flush are don't-care (o_valid=0).
//  - Reset asserted mid-transfer: state EMPTY immediately; no stale o_valid after deassertion.
// STRUCTURE
//  - Package id_imm_pkg: imm_fmt_e enum, opcode localparams (OPC_OP_IMM..OPC_SYSTEM),
//    RVC quadrant/funct3 constants, skid_state_e {EMPTY,ONE,TWO}.
//  - Sub-module id_imm_decode (combinational, params XLEN, RVC_EN): i_instr -> imm/fmt/illegal.
//    id_imm_unit instantiates it once on the input side and owns the skid FSM/registers.
// TESTING
//  1. 0xFFF00093 (addi x1,x0,-1), i_ready=1 -> next cycle o_valid=1, o_imm=0xFFFFFFFF, o_fmt=I.
//  2. 0xFE000EE3 (beq x0,x0,-4) -> o_imm=0xFFFFFFFC, fmt=B; 0x123452B7 (lui) -> 0x12345000, fmt=U.
//  3. XLEN=64: 0x80000037 -> o_imm=0xFFFFFFFF80000000; RVC 0x557D (c.li a0,-1) -> all-ones, fmt=CI;
//     RVC_EN=0 same word -> o_illegal=1, imm=0.
//  4. Backpressure: send A,B,C back-to-back, i_ready=0 for 3 cycles -> o_ready=0 after B,
//     A held stable; release -> A,B,C out in order, none lost.
//  5. State TWO, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, input dropped.
//  6. Assert i_rst async mid-stream in TWO -> o_valid=0 same cycle; 0x00000000 input -> o_illegal=1.

Source files
------------

// File: rtl/id_imm_pkg.sv
// Shared types and encodings for the ID-stage immediate generator:
// immediate formats, base/RVC opcode fields and the skid buffer states.
package id_imm_pkg;

    typedef enum logic [3:0] {
        FMT_NONE = 4'd0,
        FMT_I    = 4'd1,
        FMT_S    = 4'd2,
        FMT_B    = 4'd3,
        FMT_U    = 4'd4,
        FMT_J    = 4'd5,
        FMT_Z    = 4'd6,
        FMT_CI   = 4'd7,
        FMT_CL   = 4'd8,
        FMT_CS   = 4'd9,
        FMT_CB   = 4'd10,
        FMT_CJ   = 4'd11
    } imm_fmt_e;

    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [1:0] C_Q0 = 2'b00;
    localparam logic [1:0] C_Q1 = 2'b01;
    localparam logic [1:0] C_Q2 = 2'b10;

    localparam logic [2:0] C0_LW   = 3'b010;
    localparam logic [2:0] C0_SW   = 3'b110;
    localparam logic [2:0] C1_ADDI = 3'b000;
    localparam logic [2:0] C1_JAL  = 3'b001;
    localparam logic [2:0] C1_LI   = 3'b010;
    localparam logic [2:0] C1_LUI  = 3'b011;
    localparam logic [2:0] C1_J    = 3'b101;
    localparam logic [2:0] C1_BEQZ = 3'b110;
    localparam logic [2:0] C1_BNEZ = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/id_imm_unit_if.sv
// Handshake bundle between IF/ID (instruction in) and ID/EX (decoded immediate out).
// slave is the unit's view, master the surrounding pipeline's view.
interface id_imm_unit_if #(
    parameter int XLEN = 32
);
    import id_imm_pkg::*;

    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_instr;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_imm;
    imm_fmt_e         o_fmt;
    logic             o_illegal;
    logic [31:0]      o_instr;

    modport slave (
        input  i_valid, i_instr, i_ready,
        output o_ready, o_valid, o_imm, o_fmt, o_illegal, o_instr
    );

    modport master (
        output i_valid, i_instr, i_ready,
        input  o_ready, o_valid, o_imm, o_fmt, o_illegal, o_instr
    );

endinterface

// File: rtl/id_imm_decode.sv
// Combinational immediate decoder: RV32/RV64 base formats, CSR zimm and an RVC subset.
// All immediates are built as a signed 32-bit value and sign-extended to XLEN.
module id_imm_decode
    import id_imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit RVC_EN = 1'b1
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o,
    output logic            illegal_o
);

    logic signed [31:0] imm32;
    logic [6:0]         opc;
    logic [1:0]         quad;
    logic [2:0]         c_f3;

    assign opc  = instr_i[6:0];
    assign quad = instr_i[1:0];
    assign c_f3 = instr_i[15:13];

    always_comb begin
        imm32     = '0;
        fmt_o     = FMT_NONE;
        illegal_o = 1'b0;
        if (instr_i == 32'd0) begin
            illegal_o = 1'b1;
        end else if (quad == 2'b11) begin
            case (opc)
                OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                    fmt_o = FMT_I;
                    imm32 = 32'($signed(instr_i[31:20]));
                end
                OPC_STORE: begin
                    fmt_o = FMT_S;
                    imm32 = 32'($signed({instr_i[31:25], instr_i[11:7]}));
                end
                OPC_BRANCH: begin
                    fmt_o = FMT_B;
                    imm32 = 32'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                         instr_i[11:8], 1'b0}));
                end
                OPC_LUI, OPC_AUIPC: begin
                    fmt_o = FMT_U;
                    imm32 = {instr_i[31:12], 12'b0};
                end
                OPC_JAL: begin
                    fmt_o = FMT_J;
                    imm32 = 32'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                         instr_i[30:21], 1'b0}));
                end
                OPC_SYSTEM: begin
                    // CSRxxI variants carry a 5-bit unsigned zimm in the rs1 field
                    if (instr_i[14]) begin
                        fmt_o = FMT_Z;
                        imm32 = {27'b0, instr_i[19:15]};
                    end
                end
                OPC_OP, OPC_MISC_MEM: ;
                default: illegal_o = 1'b1;
            endcase
        end else if (!RVC_EN) begin
            illegal_o = 1'b1;
        end else begin
            case (quad)
                C_Q0: begin
                    case (c_f3)
                        C0_LW: begin
                            fmt_o = FMT_CL;
                            imm32 = {25'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
                        end
                        C0_SW: begin
                            fmt_o = FMT_CS;
                            imm32 = {25'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00};
                        end
                        default: illegal_o = 1'b1;
                    endcase
                end
                C_Q1: begin
                    case (c_f3)
                        C1_ADDI, C1_LI: begin
                            fmt_o = FMT_CI;
                            imm32 = 32'($signed({instr_i[12], instr_i[6:2]}));
                        end
                        C1_LUI: begin
                            // rd==x2 is C.ADDI16SP, which this subset does not decode
                            if (instr_i[11:7] == 5'd2) begin
                                illegal_o = 1'b1;
                            end else begin
                                fmt_o = FMT_CI;
                                imm32 = 32'($signed({instr_i[12], instr_i[6:2], 12'b0}));
                            end
                        end
                        C1_BEQZ, C1_BNEZ: begin
                            fmt_o = FMT_CB;
                            imm32 = 32'($signed({instr_i[12], instr_i[6:5], instr_i[2],
                                                 instr_i[11:10], instr_i[4:3], 1'b0}));
                        end
                        C1_J, C1_JAL: begin
                            fmt_o = FMT_CJ;
                            imm32 = 32'($signed({instr_i[12], instr_i[8], instr_i[10:9],
                                                 instr_i[6], instr_i[7], instr_i[2],
                                                 instr_i[11], instr_i[5:3], 1'b0}));
                        end
                        default: illegal_o = 1'b1;
                    endcase
                end
                C_Q2: illegal_o = 1'b1;
                default: illegal_o = 1'b1;
            endcase
        end
    end

    assign imm_o = XLEN'(imm32);

endmodule

// File: rtl/id_imm_unit.sv
// ID-stage immediate unit: decodes on the input side and buffers results in a
// 2-entry skid (output register + skid register) so o_ready never depends on i_ready.
module id_imm_unit
    import id_imm_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit RVC_EN = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_flush,
    id_imm_unit_if.slave  bus
);

    typedef struct packed {
        logic [XLEN-1:0] imm;
        imm_fmt_e        fmt;
        logic            illegal;
        logic [31:0]     instr;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, fmt: FMT_NONE, illegal: 1'b0, instr: '0};

    skid_state_e state_q, state_d;
    entry_t      out_q, out_d;
    entry_t      skid_q, skid_d;
    entry_t      dec;
    logic        in_fire;
    logic        out_fire;

    id_imm_decode #(
        .XLEN   (XLEN),
        .RVC_EN (RVC_EN)
    ) u_decode (
        .instr_i   (bus.i_instr),
        .imm_o     (dec.imm),
        .fmt_o     (dec.fmt),
        .illegal_o (dec.illegal)
    );
    assign dec.instr = bus.i_instr;

    assign bus.o_ready = (state_q != ST_TWO);
    assign bus.o_valid = (state_q != ST_EMPTY);
    assign in_fire     = bus.i_valid && bus.o_ready;
    assign out_fire    = bus.o_valid && bus.i_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        if (i_flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        out_d   = dec;
                        state_d = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        out_d = dec;
                    end else if (in_fire) begin
                        skid_d  = dec;
                        state_d = ST_TWO;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_fire) begin
                        out_d   = skid_q;
                        state_d = ST_ONE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            out_q   <= ENTRY_RST;
            skid_q  <= ENTRY_RST;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    assign bus.o_imm     = out_q.imm;
    assign bus.o_fmt     = out_q.fmt;
    assign bus.o_illegal = out_q.illegal;
    assign bus.o_instr   = out_q.instr;

endmodule

// File: tb/tb_id_imm_unit.sv
// Bench for id_imm_unit: three configurations driven in lockstep, checked against an
// occupancy-queue model and an arithmetic reference decoder.
module tb_id_imm_unit;
    import id_imm_pkg::*;

    logic clk;
    logic rst;
    logic flush;
    int   checks;
    int   failures;
    logic [31:0] q[$];

    id_imm_unit_if #(.XLEN(32)) b0 ();
    id_imm_unit_if #(.XLEN(64)) b1 ();
    id_imm_unit_if #(.XLEN(64)) b2 ();

    id_imm_unit #(.XLEN(32), .RVC_EN(1'b1)) dut0 (.i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(b0));
    id_imm_unit #(.XLEN(64), .RVC_EN(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(b1));
    id_imm_unit #(.XLEN(64), .RVC_EN(1'b0)) dut2 (.i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint fld(logic [31:0] x, int hi, int lo);
        longint w;
        w = longint'({32'b0, x});
        return (w >> lo) & ((longint'(1) << (hi - lo + 1)) - 1);
    endfunction

    // Reference decoder: field values weighted by their bit positions, then sign-wrapped.
    task automatic ref_dec(input logic [31:0] ins, input bit x64, input bit rvc,
                           output logic [63:0] imm, output imm_fmt_e fmt, output bit ill);
        longint v;
        longint opc;
        longint f3;
        longint qd;
        v = 0; fmt = FMT_NONE; ill = 1'b0;
        opc = fld(ins, 6, 0); f3 = fld(ins, 15, 13); qd = fld(ins, 1, 0);
        if (ins == 32'd0) begin
            ill = 1'b1;
        end else if (qd == 3) begin
            if (opc == 'h13 || opc == 'h03 || opc == 'h67) begin
                fmt = FMT_I; v = fld(ins, 31, 20); if (v >= 2048) v -= 4096;
            end else if (opc == 'h23) begin
                fmt = FMT_S; v = fld(ins, 31, 25) * 32 + fld(ins, 11, 7); if (v >= 2048) v -= 4096;
            end else if (opc == 'h63) begin
                fmt = FMT_B;
                v = fld(ins, 31, 31) * 4096 + fld(ins, 7, 7) * 2048 + fld(ins, 30, 25) * 32 + fld(ins, 11, 8) * 2;
                if (v >= 4096) v -= 8192;
            end else if (opc == 'h37 || opc == 'h17) begin
                fmt = FMT_U; v = fld(ins, 31, 12) * 4096; if (v >= 64'sh8000_0000) v -= 64'sh1_0000_0000;
            end else if (opc == 'h6F) begin
                fmt = FMT_J;
                v = fld(ins, 31, 31) * (1 << 20) + fld(ins, 19, 12) * 4096 + fld(ins, 20, 20) * 2048 + fld(ins, 30, 21) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end else if (opc == 'h73) begin
                if (fld(ins, 14, 14) == 1) begin fmt = FMT_Z; v = fld(ins, 19, 15); end
            end else if (opc == 'h33 || opc == 'h0F) begin
                v = 0;
            end else begin
                ill = 1'b1;
            end
        end else if (!rvc) begin
            ill = 1'b1;
        end else if (qd == 1 && (f3 == 0 || f3 == 2)) begin
            fmt = FMT_CI; v = fld(ins, 12, 12) * 32 + fld(ins, 6, 2); if (v >= 32) v -= 64;
        end else if (qd == 1 && f3 == 3 && fld(ins, 11, 7) != 2) begin
            fmt = FMT_CI; v = (fld(ins, 12, 12) * 32 + fld(ins, 6, 2)) * 4096;
            if (v >= (1 << 17)) v -= (1 << 18);
        end else if (qd == 0 && (f3 == 2 || f3 == 6)) begin
            fmt = (f3 == 2) ? FMT_CL : FMT_CS;
            v = fld(ins, 5, 5) * 64 + fld(ins, 12, 10) * 8 + fld(ins, 6, 6) * 4;
        end else if (qd == 1 && (f3 == 6 || f3 == 7)) begin
            fmt = FMT_CB;
            v = fld(ins, 12, 12) * 256 + fld(ins, 6, 5) * 64 + fld(ins, 2, 2) * 32 + fld(ins, 11, 10) * 8 + fld(ins, 4, 3) * 2;
            if (v >= 256) v -= 512;
        end else if (qd == 1 && (f3 == 1 || f3 == 5)) begin
            fmt = FMT_CJ;
            v = fld(ins, 12, 12) * 2048 + fld(ins, 11, 11) * 16 + fld(ins, 10, 9) * 256 + fld(ins, 8, 8) * 1024
              + fld(ins, 7, 7) * 64 + fld(ins, 6, 6) * 128 + fld(ins, 5, 3) * 2 + fld(ins, 2, 2) * 32;
            if (v >= 2048) v -= 4096;
        end else begin
            ill = 1'b1;
        end
        imm = x64 ? 64'(v) : {32'b0, v[31:0]};
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input bit rst_chk);
        logic        ov, orr, oill;
        logic [63:0] oimm, eimm;
        imm_fmt_e    ofmt, efmt;
        logic [31:0] oins;
        bit          eill;
        for (int k = 0; k < 3; k++) begin
            case (k)
                0: begin ov = b0.o_valid; orr = b0.o_ready; oimm = 64'(b0.o_imm);
                         ofmt = b0.o_fmt; oill = b0.o_illegal; oins = b0.o_instr; end
                1: begin ov = b1.o_valid; orr = b1.o_ready; oimm = b1.o_imm;
                         ofmt = b1.o_fmt; oill = b1.o_illegal; oins = b1.o_instr; end
                default: begin ov = b2.o_valid; orr = b2.o_ready; oimm = b2.o_imm;
                         ofmt = b2.o_fmt; oill = b2.o_illegal; oins = b2.o_instr; end
            endcase
            chk($sformatf("d%0d_ready", k), 64'(orr), 64'(q.size() < 2));
            chk($sformatf("d%0d_valid", k), 64'(ov), 64'(q.size() > 0));
            if (q.size() > 0) begin
                ref_dec(q[0], k != 0, k != 2, eimm, efmt, eill);
                chk($sformatf("d%0d_imm[%h]", k, q[0]), oimm, eimm);
                chk($sformatf("d%0d_fmt[%h]", k, q[0]), 64'(ofmt), 64'(efmt));
                chk($sformatf("d%0d_illegal[%h]", k, q[0]), 64'(oill), 64'(eill));
                chk($sformatf("d%0d_instr", k), 64'(oins), 64'(q[0]));
            end else if (rst_chk) begin
                chk($sformatf("d%0d_rst_imm", k), oimm, 64'd0);
                chk($sformatf("d%0d_rst_fmt", k), 64'(ofmt), 64'(FMT_NONE));
                chk($sformatf("d%0d_rst_illegal", k), 64'(oill), 64'd0);
                chk($sformatf("d%0d_rst_instr", k), 64'(oins), 64'd0);
            end
        end
    endtask

    task automatic drive(input bit v, input bit r, input logic [31:0] ins, input bit fl);
        b0.i_valid = v; b0.i_ready = r; b0.i_instr = ins;
        b1.i_valid = v; b1.i_ready = r; b1.i_instr = ins;
        b2.i_valid = v; b2.i_ready = r; b2.i_instr = ins;
        flush = fl;
    endtask

    // One clock: apply inputs, advance the occupancy model across the edge, then compare.
    task automatic cyc(input bit v, input bit r, input logic [31:0] ins, input bit fl);
        bit can_in;
        bit has_out;
        drive(v, r, ins, fl);
        can_in  = q.size() < 2;
        has_out = q.size() > 0;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
        end else begin
            if (has_out && r) void'(q.pop_front());
            if (v && can_in) q.push_back(ins);
        end
        check_outputs(1'b0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  opcs [11];
        opcs = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h0F};
        w = $urandom;
        case ($urandom_range(3))
            0: ;
            1: w[6:0] = opcs[$urandom_range(10)];
            2: w = {16'b0, w[15:0]};
            default: w[1:0] = 2'(($urandom_range(2)));
        endcase
        return w;
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b1);
        rst = 1'b0;

        // directed decode values
        cyc(1, 1, 32'hFFF0_0093, 0);
        cyc(1, 1, 32'hFE00_0EE3, 0);
        cyc(1, 1, 32'h1234_52B7, 0);
        cyc(1, 1, 32'h8000_0037, 0);
        cyc(1, 1, 32'h0000_557D, 0);
        cyc(1, 1, 32'h0000_0000, 0);
        cyc(1, 1, 32'h0050_5073, 0);
        cyc(1, 1, 32'h0000_4108, 0);
        cyc(1, 1, 32'h0000_C10C, 0);
        cyc(1, 1, 32'h0000_DD7D, 0);
        cyc(1, 1, 32'h0000_BFFD, 0);
        cyc(1, 1, 32'h0000_7FFD, 0);
        cyc(1, 1, 32'h0000_6105, 0);
        cyc(1, 1, 32'hFFFF_FFFF, 0);
        cyc(0, 1, 32'h0, 0);

        // backpressure: A,B,C with EX stalled, C held until accepted
        cyc(1, 0, 32'h0010_0093, 0);
        cyc(1, 0, 32'h0020_0113, 0);
        cyc(1, 0, 32'h0030_0193, 0);
        cyc(1, 0, 32'h0030_0193, 0);
        cyc(1, 1, 32'h0030_0193, 0);
        cyc(1, 1, 32'h0030_0193, 0);
        cyc(0, 1, 32'h0, 0);
        cyc(0, 1, 32'h0, 0);

        // flush while full with a concurrent input
        cyc(1, 0, 32'h0040_0213, 0);
        cyc(1, 0, 32'h0050_0293, 0);
        cyc(1, 0, 32'h0060_0313, 1);
        cyc(0, 1, 32'h0, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(3) != 0), ($urandom_range(2) != 0), rand_instr(),
                ($urandom_range(31) == 0));
        end
        cyc(0, 1, 32'h0, 0);
        cyc(0, 1, 32'h0, 0);

        // asynchronous reset in the middle of a full buffer
        cyc(1, 0, 32'h0070_0393, 0);
        cyc(1, 0, 32'h0080_0413, 0);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        check_outputs(1'b1);
        drive(0, 1, 32'h0, 0);
        @(posedge clk);
        #1;
        check_outputs(1'b1);
        rst = 1'b0;
        cyc(1, 1, 32'h0000_0000, 0);
        cyc(0, 1, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
